// File: rtl/alu_pkg.sv
// Shared ALU-datapath types: operand width, debounce default and loader states.
package alu_pkg;
    localparam int ALU_WIDTH        = 8;
    localparam int DEBOUNCE_DEFAULT = 250000;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } ld_state_t;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter debouncer and one-cycle rising press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic          stable, stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            stable_q <= stable;
            // any return to the stable level restarts the qualification window
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = stable & ~stable_q;
endmodule

// File: rtl/operand_loader.sv
// Captures ALU operands A/B from switches on debounced load presses.
// Optional OPERAND_LOADER_DIRECT_SEL_EN: sel picks the target register.
module operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH           = ALU_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_load,
`ifdef OPERAND_LOADER_DIRECT_SEL_EN
    input  logic             sel,
`endif
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic             operands_valid,
    output logic [1:0]       ld_state
);
    logic             press;
    logic [WIDTH-1:0] a_d, b_d;
    logic             valid_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_load),
        .press(press)
    );

`ifdef OPERAND_LOADER_DIRECT_SEL_EN
    logic a_ld_q, a_ld_d;
    logic b_ld_q, b_ld_d;

    always_comb begin
        a_d    = reg_a;
        b_d    = reg_b;
        a_ld_d = a_ld_q;
        b_ld_d = b_ld_q;
        if (press) begin
            if (sel) begin
                b_d    = data_in;
                b_ld_d = 1'b1;
            end else begin
                a_d    = data_in;
                a_ld_d = 1'b1;
            end
        end
        valid_d = a_ld_d & b_ld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ld_q <= 1'b0;
            b_ld_q <= 1'b0;
        end else begin
            a_ld_q <= a_ld_d;
            b_ld_q <= b_ld_d;
        end
    end

    assign ld_state = {b_ld_q, a_ld_q};
`else
    ld_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        a_d     = reg_a;
        b_d     = reg_b;
        valid_d = operands_valid;
        if (press) begin
            case (state_q)
                WAIT_A: begin
                    a_d     = data_in;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    b_d     = data_in;
                    valid_d = 1'b1;
                    state_d = READY;
                end
                READY: begin
                    a_d     = data_in;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_A;
        else        state_q <= state_d;
    end

    assign ld_state = state_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a          <= '0;
            reg_b          <= '0;
            operands_valid <= 1'b0;
        end else begin
            reg_a          <= a_d;
            reg_b          <= b_d;
            operands_valid <= valid_d;
        end
    end
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window.
module tb_operand_loader;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_load = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] reg_a, reg_b;
    logic         operands_valid;
    logic [1:0]   ld_state;

    int n_chk = 0;
    int n_bad = 0;

    operand_loader #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_load      (btn_load),
`ifdef OPERAND_LOADER_DIRECT_SEL_EN
        .sel           (sel),
`endif
        .data_in       (data_in),
        .reg_a         (reg_a),
        .reg_b         (reg_b),
        .operands_valid(operands_valid),
        .ld_state      (ld_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic v,
                           input logic [1:0] s);
        chk({tag, ".reg_a"}, 32'(reg_a), 32'(a));
        chk({tag, ".reg_b"}, 32'(reg_b), 32'(b));
        chk({tag, ".valid"}, 32'(operands_valid), 32'(v));
        chk({tag, ".state"}, 32'(ld_state), 32'(s));
    endtask

    // button goes high now; capture lands on the 7th following edge
    task automatic press_and_hold(input logic [W-1:0] d);
        data_in  = d;
        btn_load = 1'b1;
        tick(D + 3);
    endtask

    task automatic release_btn();
        tick(3);
        btn_load = 1'b0;
        tick(10);
    endtask

    initial begin
        #3;
        chk_all("reset", 8'h00, 8'h00, 1'b0, 2'b00);
        tick(1);
        rst_n = 1'b1;

`ifdef OPERAND_LOADER_DIRECT_SEL_EN
        sel = 1'b1;
        press_and_hold(8'h11);
        chk_all("sel_b", 8'h00, 8'h11, 1'b0, 2'b10);
        release_btn();
        sel = 1'b0;
        press_and_hold(8'h22);
        chk_all("sel_a", 8'h22, 8'h11, 1'b1, 2'b11);
        release_btn();
        sel = 1'b0;
        press_and_hold(8'h33);
        chk_all("sel_a2", 8'h33, 8'h11, 1'b1, 2'b11);
        release_btn();
`else
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_all("idle", 8'h00, 8'h00, 1'b0, 2'b00);
        end

        data_in  = 8'h3C;
        btn_load = 1'b1;
        tick(D + 2);
        chk("a_early", 32'(reg_a), 32'h00);
        tick(1);
        chk_all("load_a", 8'h3C, 8'h00, 1'b0, 2'b01);
        release_btn();
        chk_all("release_a", 8'h3C, 8'h00, 1'b0, 2'b01);

        press_and_hold(8'hA5);
        chk_all("load_b", 8'h3C, 8'hA5, 1'b1, 2'b10);
        release_btn();

        for (int len = 1; len < D; len++) begin
            data_in  = 8'h66;
            btn_load = 1'b1;
            tick(len);
            btn_load = 1'b0;
            tick(10);
            chk_all("glitch", 8'h3C, 8'hA5, 1'b1, 2'b10);
        end

        data_in = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            btn_load = (i % 2 == 0);
            tick(2);
        end
        btn_load = 1'b1;
        tick(12);
        chk_all("bounce_ready_a", 8'hFF, 8'hA5, 1'b0, 2'b01);
        release_btn();
        chk_all("bounce_one", 8'hFF, 8'hA5, 1'b0, 2'b01);

        press_and_hold(8'h5A);
        chk_all("load_b2", 8'hFF, 8'h5A, 1'b1, 2'b10);
        release_btn();

        data_in  = 8'h77;
        btn_load = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #2;
        chk_all("async_rst", 8'h00, 8'h00, 1'b0, 2'b00);
        rst_n = 1'b1;
        tick(D + 2);
        chk("rst_hold_early", 32'(reg_a), 32'h00);
        tick(1);
        chk_all("rst_hold", 8'h77, 8'h00, 1'b0, 2'b01);
        release_btn();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream operand stage that feeds the 8-bit ALU datapath.
- Debounces the raw load push-button and turns each clean press into a single load event.
- Sequences those events to capture operand A, then operand B, from the data switches.
- Presents both operands as registered values with a validity flag to the ALU; the seven-segment flag display and LED drivers consume the ALU result downstream.

Parameters:
- WIDTH, 8, operand width in bits.
- DEBOUNCE_CYCLES, 250000, number of consecutive clk cycles the synchronized button level must differ from the stable level before the stable level flips; minimum 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_load  input  1  raw, asynchronous, bouncing load push-button (active high).
- data_in  input  WIDTH  operand switches; quasi-static, sampled directly at the capture edge.
- reg_a  output  WIDTH  captured operand A.
- reg_b  output  WIDTH  captured operand B.
- operands_valid  output  1  high when reg_a and reg_b both hold captured values since the last A load.
- ld_state  output  2  current FSM state encoding (00 WAIT_A, 01 WAIT_B, 10 READY) for status LEDs.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low; all flops clear on assertion with no clock required.
- Reset values: reg_a=0, reg_b=0, operands_valid=0, ld_state=00 (WAIT_A), sync flops=0, stable=0, debounce counter=0.
- Synchronizer: two flops s1->s2 on btn_load.
- Debounce counter:
  - if s2 != stable: cnt <= cnt+1; when cnt == DEBOUNCE_CYCLES-1, then stable <= s2 and cnt <= 0.
  - if s2 == stable: cnt <= 0.
  - Counter width: $clog2(DEBOUNCE_CYCLES).
- Press pulse: press = stable & ~stable_q, where stable_q is stable delayed one cycle. The pulse is exactly one cycle wide. Release edges produce no event.
- Latency: button high and held from before edge 1 -> capture registers update on edge DEBOUNCE_CYCLES+3. With DEBOUNCE_CYCLES=4, capture occurs on edge 7.
- Glitch rejection: any excursion of s2 shorter than DEBOUNCE_CYCLES cycles resets cnt and produces no press.
- FSM, transitions on press only; with no press, the state and all outputs hold:
  - WAIT_A: reg_a <= data_in; -> WAIT_B.
  - WAIT_B: reg_b <= data_in; operands_valid <= 1; -> READY.
  - READY: reg_a <= data_in; operands_valid <= 0; -> WAIT_B. reg_b retains its old value until overwritten.
- operands_valid is registered and changes on the same edge as the capture.
- Reset mid-debounce or mid-sequence: everything clears immediately. A button still held at reset release counts as a new press after DEBOUNCE_CYCLES+3 cycles.
- data_in is not synchronized: switches must be stable at the capture edge, a user-level guarantee.

Optional Feature:
- Macro: OPERAND_LOADER_DIRECT_SEL_EN.
- Defined:
  - Adds input port sel (1 bit), sampled at the press edge.
  - press with sel=0 loads reg_a; press with sel=1 loads reg_b.
  - operands_valid goes high once both registers have been loaded at least once since reset, and then stays high.
  - ld_state reports {b_loaded, a_loaded}.
- Undefined: sequential A/B FSM as above; no sel port.

Decomposition:
- Shared package alu_pkg:
  - ld_state_t enum (WAIT_A=2'b00, WAIT_B=2'b01, READY=2'b10).
  - ALU_WIDTH=8.
  - DEBOUNCE_DEFAULT=250000.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES): synchronizer, counter, stable level, one-cycle press output. operand_loader instantiates it and contains only the FSM and capture registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle -> reg_a=0, reg_b=0, operands_valid=0, ld_state=00 for 20 cycles.
- Clean press with data_in=8'h3C held 10 cycles -> reg_a=8'h3C on edge 7 after press start, ld_state=01, operands_valid=0. Release, then press with data_in=8'hA5 -> reg_b=8'hA5, operands_valid=1, ld_state=10.
- Bounce: toggle btn_load every 2 cycles for 12 cycles, then hold high -> exactly one capture. Glitches of 1-3 cycles alone -> no capture.
- From READY, press with data_in=8'hFF -> reg_a=8'hFF, operands_valid=0, ld_state=01, reg_b unchanged at 8'hA5.
- Assert rst_n low mid-debounce (cnt=2) and in READY -> all outputs 0 asynchronously. Button held through reset release -> one capture into reg_a after 7 edges.
- With OPERAND_LOADER_DIRECT_SEL_EN: sel=1 press data 8'h11 -> reg_b=8'h11, valid=0. Then sel=0 press data 8'h22 -> reg_a=8'h22, valid=1.
